// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
//
// Multi-channel input synchroniser for the SPI slave pins (SCK, CS_N, MOSI).
// Each channel runs through a C_SYNC_STAGES-deep flip-flop chain, then an
// optional persistence filter that only accepts a new level after it has been
// seen for C_FILTER_LEN consecutive cycles. One-cycle rise/fall pulses are
// produced from the final level so the SPI core needs no edge detectors.
//
// Parameters
//   C_DATA_WIDTH   number of independent channels
//   C_SYNC_STAGES  synchroniser depth, 2..4 (use 3 above ~200 MHz)
//   C_FILTER_LEN   persistence length in cycles, 0..15 (0 = no filter)
//   C_RESET_VALUE  per-channel reset level (CS_N bit should be 1)
//
// Ports
//   clk   in   sampling clock
//   rst   in   asynchronous, active-high reset
//   din   in   asynchronous pin inputs
//   dout  out  synchronised, filtered level
//   rise  out  one-cycle pulse on dout 0->1
//   fall  out  one-cycle pulse on dout 1->0
// -----------------------------------------------------------------------------
module spi_slave_sync #(
   parameter int                      C_DATA_WIDTH  = 3,
   parameter int                      C_SYNC_STAGES = 2,
   parameter int                      C_FILTER_LEN  = 0,
   parameter logic [C_DATA_WIDTH-1:0] C_RESET_VALUE = {C_DATA_WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [C_DATA_WIDTH-1:0] din,
   output logic [C_DATA_WIDTH-1:0] dout,
   output logic [C_DATA_WIDTH-1:0] rise,
   output logic [C_DATA_WIDTH-1:0] fall
);

   // ---- synchroniser chain ----
   // Stage 0 is kept separate so it alone can be packed into the IOB.
   (* ASYNC_REG = "true", IOB = "true" *) logic [C_DATA_WIDTH-1:0] s0_q;
   (* ASYNC_REG = "true" *) logic [C_DATA_WIDTH-1:0] s_q [1:C_SYNC_STAGES-1];
   logic [C_DATA_WIDTH-1:0] s0_d;
   logic [C_DATA_WIDTH-1:0] s_d [1:C_SYNC_STAGES-1];
   logic [C_DATA_WIDTH-1:0] sync;

   always_comb begin
      s0_d   = din;
      s_d[1] = s0_q;
      for (int k = 2; k < C_SYNC_STAGES; k++) begin
         s_d[k] = s_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_q <= C_RESET_VALUE;
         for (int k = 1; k < C_SYNC_STAGES; k++) begin
            s_q[k] <= C_RESET_VALUE;
         end
      end else begin
         s0_q <= s0_d;
         for (int k = 1; k < C_SYNC_STAGES; k++) begin
            s_q[k] <= s_d[k];
         end
      end
   end

   assign sync = s_q[C_SYNC_STAGES-1];

   // ---- persistence filter ----
   generate
      if (C_FILTER_LEN == 0) begin : gen_bypass
         assign dout = sync;
      end else begin : gen_filt
         localparam int CNT_W = (C_FILTER_LEN <= 1) ? 1 : $clog2(C_FILTER_LEN + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_FILTER_LEN - 1);

         logic [C_DATA_WIDTH-1:0] lvl_q, lvl_d;
         logic [CNT_W-1:0]        cnt_q [C_DATA_WIDTH];
         logic [CNT_W-1:0]        cnt_d [C_DATA_WIDTH];

         // The counter restarts whenever sync agrees with lvl, so only an
         // unbroken run of C_FILTER_LEN mismatching cycles moves lvl; it
         // clears on acceptance and therefore never passes CNT_LAST.
         always_comb begin
            lvl_d = lvl_q;
            for (int i = 0; i < C_DATA_WIDTH; i++) begin
               cnt_d[i] = cnt_q[i];
               if (sync[i] == lvl_q[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  lvl_d[i] = sync[i];
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lvl_q <= C_RESET_VALUE;
               for (int i = 0; i < C_DATA_WIDTH; i++) begin
                  cnt_q[i] <= '0;
               end
            end else begin
               lvl_q <= lvl_d;
               for (int i = 0; i < C_DATA_WIDTH; i++) begin
                  cnt_q[i] <= cnt_d[i];
               end
            end
         end

         assign dout = lvl_q;
      end
   endgenerate

   // ---- edge detection ----
   // dq resets to the same value as dout, so no pulse fires on reset release.
   logic [C_DATA_WIDTH-1:0] dq_q, dq_d;

   assign dq_d = dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dq_q <= C_RESET_VALUE;
      end else begin
         dq_q <= dq_d;
      end
   end

   assign rise = dout & ~dq_q;
   assign fall = ~dout & dq_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sync
//
// Eleven instances of spi_slave_sync (depth 2..4 crossed with filter length
// 0/1/4, plus 2/3 and 3/2) share one clock, reset and din. Each instance has a
// reference model: the sync output is din delayed by the chain depth, and the
// filtered level flips once the last L sync samples all disagree with it.
// One process compares every instance against its model every cycle and adds
// literal expectations for reset, reset release and step latency.
// -----------------------------------------------------------------------------
module tb_spi_slave_sync;

   localparam int         NC   = 11;
   localparam int         HLEN = 12;
   localparam logic [2:0] RV   = 3'b010;

   function automatic int cfg_s(input int n);
      if (n == 9)  return 2;
      if (n == 10) return 3;
      return 2 + (n % 3);
   endfunction

   function automatic int cfg_l(input int n);
      if (n == 9)  return 3;
      if (n == 10) return 2;
      if (n < 3)   return 0;
      if (n < 6)   return 1;
      return 4;
   endfunction

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] din;
   int         edge_cnt = 0;
   int         rel_at   = -100;
   int         step_at  = -100;
   int         n_tot    = 0;
   int         n_bad    = 0;

   logic [2:0] dout_a  [NC];
   logic [2:0] rise_a  [NC];
   logic [2:0] fall_a  [NC];
   logic [2:0] exp_d_a [NC];
   logic [2:0] exp_p_a [NC];

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   for (genvar g = 0; g < NC; g++) begin : gi
      localparam int S = cfg_s(g);
      localparam int L = cfg_l(g);

      spi_slave_sync #(
         .C_DATA_WIDTH (3),
         .C_SYNC_STAGES(S),
         .C_FILTER_LEN (L),
         .C_RESET_VALUE(RV)
      ) dut (
         .clk (clk),
         .rst (rst),
         .din (din),
         .dout(dout_a[g]),
         .rise(rise_a[g]),
         .fall(fall_a[g])
      );

      // h[0] is din taken at the most recent edge; sync is h[S-1] and the
      // sync values before it are h[S], h[S+1], ...
      logic [2:0] h [HLEN];
      logic [2:0] lvl, prev, nl, cur;
      logic       run;

      always_comb begin
         nl  = lvl;
         run = 1'b0;
         for (int i = 0; i < 3; i++) begin
            run = (L > 0);
            for (int k = 0; k < L; k++) begin
               if (h[S-1+k][i] == lvl[i]) run = 1'b0;
            end
            if (run) nl[i] = ~lvl[i];
         end
      end

      assign cur = (L == 0) ? h[S-1] : lvl;

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k < HLEN; k++) h[k] <= RV;
            lvl  <= RV;
            prev <= RV;
         end else begin
            h[0] <= din;
            for (int k = 1; k < HLEN; k++) h[k] <= h[k-1];
            lvl  <= nl;
            prev <= cur;
         end
      end

      assign exp_d_a[g] = cur;
      assign exp_p_a[g] = prev;
   end

   task automatic chk(input string nm, input int g, input logic [2:0] got, input logic [2:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s inst=%0d S=%0d L=%0d cycle=%0d got=%b exp=%b",
                  nm, g, cfg_s(g), cfg_l(g), edge_cnt, got, exp);
      end
   endtask

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      if (edge_cnt >= 1) begin
         for (int g = 0; g < NC; g++) begin
            int sl;
            sl = cfg_s(g) + cfg_l(g);
            chk("dout", g, dout_a[g], exp_d_a[g]);
            chk("rise", g, rise_a[g], exp_d_a[g] & ~exp_p_a[g]);
            chk("fall", g, fall_a[g], ~exp_d_a[g] & exp_p_a[g]);
            chk("overlap", g, rise_a[g] & fall_a[g], 3'b000);
            if (rst) begin
               chk("rst_dout", g, dout_a[g], 3'b010);
               chk("rst_rise", g, rise_a[g], 3'b000);
               chk("rst_fall", g, fall_a[g], 3'b000);
            end
            if (g == 0) begin
               if (edge_cnt == rel_at + 1) chk("rel_dout1", g, dout_a[g], 3'b010);
               if (edge_cnt == rel_at + 2) begin
                  chk("rel_dout2", g, dout_a[g], 3'b101);
                  chk("rel_rise2", g, rise_a[g], 3'b101);
                  chk("rel_fall2", g, fall_a[g], 3'b010);
               end
               if (edge_cnt == rel_at + 3) begin
                  chk("rel_rise3", g, rise_a[g], 3'b000);
                  chk("rel_fall3", g, fall_a[g], 3'b000);
               end
            end
            if (edge_cnt == step_at + sl - 1) chk("lat_before", g, {2'b00, dout_a[g][0]}, 3'b000);
            if (edge_cnt == step_at + sl) begin
               chk("lat_dout", g, {2'b00, dout_a[g][0]}, 3'b001);
               chk("lat_rise", g, {2'b00, rise_a[g][0]}, 3'b001);
               chk("lat_fall", g, fall_a[g], 3'b000);
            end
            if (edge_cnt == step_at + sl + 1) chk("lat_rise_end", g, {2'b00, rise_a[g][0]}, 3'b000);
         end
      end
   end

   task automatic hold(input logic [2:0] v, input int n);
      din = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      din = 3'b101;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      rel_at = edge_cnt;
      hold(3'b101, 10);

      // latency sweep: single 0->1 step on bit 0
      hold(3'b000, 14);
      step_at = edge_cnt;
      hold(3'b001, 14);

      // glitch rejection on bit 1: 2 high, 3 high, 2/1/2
      hold(3'b000, 12);
      hold(3'b010, 2);
      hold(3'b000, 12);
      hold(3'b010, 3);
      hold(3'b000, 12);
      hold(3'b010, 2);
      hold(3'b000, 1);
      hold(3'b010, 2);
      hold(3'b000, 12);

      // channel independence: all bits rise, bit 2 drops for one cycle
      hold(3'b111, 1);
      hold(3'b011, 1);
      hold(3'b111, 12);
      hold(3'b000, 12);

      // reset in the middle of a filter run
      hold(3'b001, 4);
      rst = 1'b1;
      hold(3'b001, 2);
      rst = 1'b0;
      hold(3'b001, 15);

      // random stimulus with occasional resets
      repeat (2500) begin
         if ($urandom_range(0, 63) == 0) begin
            rst = 1'b1;
            hold(din, $urandom_range(1, 2));
            rst = 1'b0;
         end
         hold(3'($urandom), $urandom_range(1, 6));
      end

      hold(3'b000, 12);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised multi-channel input synchroniser for the SPI slave pins (SCK, CS_N, MOSI), one instance per clock domain. Each channel passes through a configurable-depth flip-flop chain, then an optional per-channel persistence (glitch) filter. It also produces one-cycle rise and fall pulses, so downstream logic needs no edge detectors of its own. It replaces the fixed two-stage synchroniser in front of the SPI slave core.

## Interface

Parameters:
- C_DATA_WIDTH, 3: number of independent channels.
- C_SYNC_STAGES, 2: synchroniser depth, legal range 2..4.
- C_FILTER_LEN, 0: number of consecutive cycles a new synchronised level must persist before `dout` accepts it.
  - Legal range 0..15.
  - 0 bypasses the filter.
- C_RESET_VALUE, {C_DATA_WIDTH{1'b0}}: per-channel reset level. Set the CS_N bit to 1.

Ports:
- clk  in  1  sampling clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  C_DATA_WIDTH  asynchronous pin inputs.
- dout  out  C_DATA_WIDTH  synchronised, filtered level.
- rise  out  C_DATA_WIDTH  one-cycle pulse when `dout[i]` goes 0→1.
- fall  out  C_DATA_WIDTH  one-cycle pulse when `dout[i]` goes 1→0.

## Operation

- Sync chain:
  - `s[0] <= din`, `s[k] <= s[k-1]`.
  - `sync = s[C_SYNC_STAGES-1]`.
  - All stages carry ASYNC_REG="true"; stage 0 also carries IOB="true".
- Filter bypass (C_FILTER_LEN=0): `dout = sync`. No filter registers exist.
- Filter active (L = C_FILTER_LEN ≥ 1): each channel has a level register `lvl[i]` and a counter `cnt[i]`, width max(1, clog2(L+1)).
  - `sync[i] == lvl[i]`: `cnt <= 0`.
  - Otherwise, if `cnt == L-1`: `lvl <= sync[i]` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - `dout = lvl`.
  - A mismatch shorter than L cycles never reaches `dout`. The counter clears the cycle `sync` returns to `lvl`; mismatch cycles do not accumulate across gaps.
- Edge pulses: register `dq <= dout`, then:
  - `rise = dout & ~dq`.
  - `fall = ~dout & dq`.
  - Each pulse is high for exactly the first cycle of the new `dout` level.
- Channels are fully independent. Simultaneous changes on several channels are each handled on their own counters; no cross-channel alignment is guaranteed.
- Reset, asynchronous, takes effect at assertion regardless of `clk`:
  - All `s[k]`, `lvl` and `dq` load C_RESET_VALUE; `cnt` loads 0.
  - Hence `dout = C_RESET_VALUE` and `rise = fall = 0` during reset and in the first cycle after release.
  - Reset mid-filter discards the partial count.
- No wrap-around: `cnt` never exceeds L-1.

## Timing

- Let S = C_SYNC_STAGES and L = C_FILTER_LEN. A `din` level that is stable from before clock edge 0 (first sampling edge) is handled as follows:
  - L=0: `dout` changes after edge S-1, i.e. S edges including the sampling edge.
  - L≥1: `sync` changes after edge S-1; `dout` changes after edge S-1+L. Total is S+L edges.
  - `rise`/`fall` assert in the same cycle `dout` changes and deassert after the next edge.
- Defaults (S=2, L=0): `din` sampled at edge 0 → `dout` valid after edge 1.
- A `sync` pulse of width w cycles (L≥1):
  - Propagated if w ≥ L.
  - Otherwise dropped entirely, with no rise/fall.
- Outputs are registered for L≥1. For L=0, `dout` comes straight from the last sync register; `rise`/`fall` are one gate level after registers.
- Metastability: 2 stages are the minimum; use 3 when `clk` exceeds 200 MHz.

## Test plan

- Reset values: C_RESET_VALUE=3'b010, hold `din`=3'b101 during reset → `dout`=3'b010, `rise`=`fall`=0. After release with S=2, L=0, `dout`=3'b101 two edges later, `rise`=3'b101 and `fall`=3'b010 for exactly one cycle.
- Latency sweep: S∈{2,3,4}, L∈{0,1,4}, single 0→1 step on `din[0]` → `dout[0]` rises after exactly S+L edges. `rise[0]` is high for one cycle; `fall` stays 0.
- Glitch rejection, L=3: `din[1]` high for 2 cycles → `dout[1]`, `rise[1]` and `fall[1]` unchanged. Pulse of 3 cycles → `dout[1]` high for 3 cycles, with one `rise` and one `fall` pulse. Pattern 2 high / 1 low / 2 high → no change, proving the counter clears.
- Reset mid-filter, L=4: step `din[0]`, assert `rst` after 2 cycles of mismatch, release, then hold `din[0]` at the new level → `dout[0]` updates exactly S+4 edges after release, not earlier.
- Channel independence: W=3, L=2, `din` toggles 3'b000→3'b111 with bit 2 glitching for 1 cycle → `dout` bits 0 and 1 rise together at S+2. Bit 2 rises only after its stable run; no pulse appears on other bits.
- Random async stimulus against a cycle model of sync+filter → `dout`/`rise`/`fall` match the model every cycle. Pulses never overlap and `cnt` is always ≤ L-1.
